// File: rtl/tgc_curve_seq_if.sv
// Bus between the TGC curve sequencer, its host and the downstream DAC controller.
// master: host/DAC side; slave: the sequencer.
interface tgc_curve_seq_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] cfg_last;
  logic              start;
  logic              abort;
  logic [DATA_W-1:0] dac_din;
  logic              dac_dvalid;
  logic              dac_busy;
  logic              active;
  logic              done;
  logic              overrun;

  modport master (
    output wr_en, wr_addr, wr_data, cfg_last, start, abort, dac_busy,
    input  dac_din, dac_dvalid, active, done, overrun
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, cfg_last, start, abort, dac_busy,
    output dac_din, dac_dvalid, active, done, overrun
  );
endinterface

// File: rtl/tgc_curve_seq.sv
// Time-gain-compensation curve sequencer: plays a stored gain curve into an MCP4811 DAC controller.
// Optional macro TGC_SKIP_DUP_EN: pending points equal to the last issued value are consumed silently.
module tgc_curve_seq #(
  parameter int DATA_W   = 10,
  parameter int DEPTH    = 32,
  parameter int STEP_DIV = 200
) (
  input  logic            clk,
  input  logic            rst_n,
  tgc_curve_seq_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(STEP_DIV);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] pend_val;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] last_q;
  logic [CNT_W-1:0]  step_cnt;
  logic              all_latched;
  logic              rd_v;
  logic              rd_last;
  logic              pend;
  logic              pend_last;
  logic              last_out;
  logic              accept;
  logic              tick;
  logic              latch;
  logic              consume;
  logic              issue;
  logic              finish;
  logic              halt;
`ifdef TGC_SKIP_DUP_EN
  logic [DATA_W-1:0] prev_val;
  logic              prev_v;
`endif

  always_ff @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (tick) rd_data <= mem[idx];
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    tick    = 1'b0;
    latch   = 1'b0;
    consume = 1'b0;
    finish  = 1'b0;
    halt    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        tick    = (step_cnt == '0) && !all_latched && !bus.abort;
        latch   = rd_v && !bus.abort;
        // dvalid guard covers the cycle before the DAC raises busy
        consume = pend && !bus.dac_busy && !bus.dac_dvalid && !bus.abort;
        finish  = last_out && !bus.abort;
        halt    = bus.abort || finish;
        if (halt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef TGC_SKIP_DUP_EN
    issue = consume && !(prev_v && (pend_val == prev_val));
`else
    issue = consume;
`endif
  end

  assign bus.active = (state_q == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx            <= '0;
      last_q         <= '0;
      step_cnt       <= '0;
      all_latched    <= 1'b0;
      rd_v           <= 1'b0;
      rd_last        <= 1'b0;
      pend           <= 1'b0;
      pend_val       <= '0;
      pend_last      <= 1'b0;
      last_out       <= 1'b0;
      bus.dac_din    <= '0;
      bus.dac_dvalid <= 1'b0;
      bus.done       <= 1'b0;
      bus.overrun    <= 1'b0;
`ifdef TGC_SKIP_DUP_EN
      prev_val       <= '0;
      prev_v         <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      bus.dac_dvalid <= issue;
      bus.done       <= finish;
      bus.overrun    <= latch && pend && !consume;
      // marks the cycle the last point is (or would have been) on the DAC bus
      last_out       <= consume && pend_last;
      rd_v           <= tick;
      if (accept) begin
        idx         <= '0;
        step_cnt    <= '0;
        last_q      <= bus.cfg_last;
        all_latched <= 1'b0;
        pend        <= 1'b0;
`ifdef TGC_SKIP_DUP_EN
        prev_v      <= 1'b0;
`endif
      end else if (state_q == RUN) begin
        step_cnt <= (step_cnt == CNT_W'(STEP_DIV - 1)) ? '0 : step_cnt + CNT_W'(1);
        if (tick) begin
          rd_last <= (idx == last_q);
          if (idx == last_q) all_latched <= 1'b1;
          else               idx         <= idx + ADDR_W'(1);
        end
        if (halt) begin
          pend <= 1'b0;
        end else if (latch) begin
          pend      <= 1'b1;
          pend_val  <= rd_data;
          pend_last <= rd_last;
        end else if (consume) begin
          pend <= 1'b0;
        end
        if (issue) begin
          bus.dac_din <= pend_val;
`ifdef TGC_SKIP_DUP_EN
          prev_val    <= pend_val;
          prev_v      <= 1'b1;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_tgc_curve_seq.sv
// Self-checking bench for tgc_curve_seq: directed curve scenarios plus randomized runs
// checked against an event-level model of the playback rules.
module tb_tgc_curve_seq;
  localparam int DATA_W = 10;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int STEP   = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tgc_curve_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  tgc_curve_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH), .STEP_DIV(STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int mem_m [DEPTH];
  int s_last, s_busy, s_abort, s_wcyc, s_waddr, s_wdata, s_restart;
  int o_dv_t[$], o_dv_v[$], o_done_t[$], o_ovr_t[$];
  int e_dv_t[$], e_dv_v[$], e_done_t[$], e_ovr_t[$];
  int o_end, e_end;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int span();
    return s_last * STEP + 2 * s_busy + 24;
  endfunction

  task automatic set_scn(input int last, input int busy);
    s_last = last; s_busy = busy; s_abort = -1;
    s_wcyc = -1; s_waddr = 0; s_wdata = 0; s_restart = -1;
  endtask

  task automatic load(input int a, input int v);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(a); bus.wr_data = DATA_W'(v);
    @(negedge clk);
    bus.wr_en = 1'b0;
    mem_m[a] = v;
  endtask

  function automatic int point_val(input int k);
    if (s_wcyc >= 0 && s_waddr == k && s_wcyc < k * STEP) return s_wdata;
    return mem_m[k];
  endfunction

  // Cycle 0 is the first RUN cycle; point k is read at k*STEP and pending from k*STEP+2.
  task automatic model_run();
    int pend = 0, pval = 0, pk = 0, dv = 0, dv_val = 0, dv_pt = 0, nxt = 0;
    int last_dv = -1000000, done_at = -1;
    bit busy;
`ifdef TGC_SKIP_DUP_EN
    int last_iss = -1;
`endif
    e_dv_t.delete(); e_dv_v.delete(); e_done_t.delete(); e_ovr_t.delete();
    e_end = span() + 1;
    for (int c = 0; c <= span(); c++) begin
      if (s_abort >= 0 && c == s_abort + 1) begin e_end = c; break; end
      if (c == done_at) begin e_done_t.push_back(c); e_end = c; break; end
      if (dv != 0) begin
        e_dv_t.push_back(c); e_dv_v.push_back(dv_val); last_dv = c;
        if (dv_pt == s_last) done_at = c + 1;
      end
      if (c >= 2 && (c - 2) % STEP == 0 && (c - 2) / STEP <= s_last) begin
        if (pend != 0) e_ovr_t.push_back(c);
        pend = 1; pk = (c - 2) / STEP; pval = point_val(pk);
      end
      busy = (c > last_dv) && (c <= last_dv + s_busy);
      nxt = 0;
      if (pend != 0 && !busy && dv == 0 && c != s_abort) begin
        pend = 0;
`ifdef TGC_SKIP_DUP_EN
        if (pval == last_iss) begin
          if (pk == s_last) done_at = c + 2;
        end else begin
          nxt = 1; dv_val = pval; dv_pt = pk; last_iss = pval;
        end
`else
        nxt = 1; dv_val = pval; dv_pt = pk;
`endif
      end
      dv = nxt;
    end
  endtask

  // Drives one run; the DAC busy response is 1 clk after each dvalid for s_busy clks.
  task automatic drive_run();
    int last_dv = -1000000;
    o_dv_t.delete(); o_dv_v.delete(); o_done_t.delete(); o_ovr_t.delete();
    o_end = -1;
    @(negedge clk);
    bus.cfg_last = ADDR_W'(s_last);
    bus.start    = 1'b1;
    for (int c = 0; c <= span(); c++) begin
      @(negedge clk);
      if (bus.dac_dvalid === 1'b1) begin
        o_dv_t.push_back(c); o_dv_v.push_back(int'(bus.dac_din)); last_dv = c;
      end
      if (bus.done === 1'b1) o_done_t.push_back(c);
      if (bus.overrun === 1'b1) o_ovr_t.push_back(c);
      if (bus.active !== 1'b1 && o_end < 0) o_end = c;
      bus.start    = (c == s_restart);
      bus.abort    = (c == s_abort);
      bus.wr_en    = (c == s_wcyc);
      bus.wr_addr  = ADDR_W'(s_waddr);
      bus.wr_data  = DATA_W'(s_wdata);
      bus.dac_busy = (c > last_dv) && (c <= last_dv + s_busy);
    end
    bus.start = 1'b0; bus.abort = 1'b0; bus.wr_en = 1'b0; bus.dac_busy = 1'b0;
    if (o_end < 0) o_end = span() + 1;
    if (s_wcyc >= 0) mem_m[s_waddr] = s_wdata;
  endtask

  task automatic test_reset();
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.cfg_last = '0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.dac_busy = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.dac_din, bus.dac_dvalid, bus.active, bus.done, bus.overrun} !== '0) begin
      failures++;
      $display("FAIL reset outputs got din=%0d dv=%b act=%b done=%b ovr=%b exp all 0",
               bus.dac_din, bus.dac_dvalid, bus.active, bus.done, bus.overrun);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    int exp_v[4] = '{100, 200, 300, 400};
    for (int i = 0; i < 4; i++) load(i, exp_v[i]);
    set_scn(3, 40);
    drive_run();
    checks++;
    if (o_dv_t.size() != 4) begin
      failures++; $display("FAIL nominal dv_count got %0d exp 4", o_dv_t.size());
    end
    for (int i = 0; i < 4 && i < o_dv_t.size(); i++) begin
      checks++;
      if (o_dv_v[i] != exp_v[i] || o_dv_t[i] != 3 + STEP * i) begin
        failures++;
        $display("FAIL nominal dv[%0d] got din=%0d t=%0d exp din=%0d t=%0d",
                 i, o_dv_v[i], o_dv_t[i], exp_v[i], 3 + STEP * i);
      end
    end
    checks++;
    if (o_done_t.size() != 1 || o_done_t[0] != 3 * STEP + 4 || o_end != 3 * STEP + 4) begin
      failures++;
      $display("FAIL nominal done got count=%0d end=%0d exp count=1 t=%0d", o_done_t.size(), o_end, 3 * STEP + 4);
    end
    checks++;
    if (o_ovr_t.size() != 0) begin
      failures++; $display("FAIL nominal overrun got %0d pulses exp 0", o_ovr_t.size());
    end
  endtask

  task automatic test_overrun();
    int exp_t[3] = '{3, 145, 287};
    int exp_v[3] = '{100, 300, 400};
    set_scn(3, 140);
    drive_run();
    checks++;
    if (o_dv_t.size() != 3) begin
      failures++; $display("FAIL overrun dv_count got %0d exp 3", o_dv_t.size());
    end
    for (int i = 0; i < 3 && i < o_dv_t.size(); i++) begin
      checks++;
      if (o_dv_v[i] != exp_v[i] || o_dv_t[i] != exp_t[i]) begin
        failures++;
        $display("FAIL overrun dv[%0d] got din=%0d t=%0d exp din=%0d t=%0d",
                 i, o_dv_v[i], o_dv_t[i], exp_v[i], exp_t[i]);
      end
    end
    checks++;
    if (o_ovr_t.size() != 1 || o_ovr_t[0] != 2 * STEP + 2) begin
      failures++; $display("FAIL overrun pulses got count=%0d exp one at %0d", o_ovr_t.size(), 2 * STEP + 2);
    end
    checks++;
    if (o_done_t.size() != 1 || o_done_t[0] != 288) begin
      failures++; $display("FAIL overrun done got count=%0d exp one at 288", o_done_t.size());
    end
  endtask

  task automatic test_abort();
    set_scn(3, 40);
    s_abort = STEP + 3 + 10;
    drive_run();
    checks++;
    if (o_end != s_abort + 1) begin
      failures++; $display("FAIL abort active_low_at got %0d exp %0d", o_end, s_abort + 1);
    end
    checks++;
    if (o_dv_t.size() != 2 || o_done_t.size() != 0) begin
      failures++;
      $display("FAIL abort after got dv=%0d done=%0d exp dv=2 done=0", o_dv_t.size(), o_done_t.size());
    end
  endtask

  task automatic test_single();
    load(0, 5);
    set_scn(0, 40);
    drive_run();
    checks++;
    if (o_dv_t.size() != 1 || o_dv_v[0] != 5 || o_dv_t[0] != 3) begin
      failures++; $display("FAIL single dv got count=%0d exp one din=5 at 3", o_dv_t.size());
    end
    checks++;
    if (o_done_t.size() != 1 || o_done_t[0] != 4 || o_end != 4) begin
      failures++; $display("FAIL single done got count=%0d end=%0d exp done at 4", o_done_t.size(), o_end);
    end
  endtask

  task automatic test_overwrite();
    for (int i = 0; i < 4; i++) load(i, 100 * (i + 1));
    set_scn(3, 40);
    s_wcyc = STEP + 17; s_waddr = 3; s_wdata = 7;
    drive_run();
    checks++;
    if (o_dv_v.size() != 4 || o_dv_v[3] != 7) begin
      failures++;
      $display("FAIL overwrite fourth_din got count=%0d last=%0d exp 7", o_dv_v.size(),
               (o_dv_v.size() > 0) ? o_dv_v[o_dv_v.size() - 1] : -1);
    end
  endtask

  task automatic test_start_abort();
    int dv_seen = 0, act_seen = 0;
    @(negedge clk);
    bus.cfg_last = '0; bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.active === 1'b1) act_seen++;
      if (bus.dac_dvalid === 1'b1) dv_seen++;
      @(negedge clk);
    end
    checks++;
    if (act_seen != 0 || dv_seen != 0) begin
      failures++; $display("FAIL start_abort got active_cycles=%0d dv=%0d exp 0 0", act_seen, dv_seen);
    end
  endtask

  task automatic test_dup();
    int exp_v[$];
    load(0, 50); load(1, 50); load(2, 60);
    set_scn(2, 40);
`ifdef TGC_SKIP_DUP_EN
    exp_v.push_back(50); exp_v.push_back(60);
`else
    exp_v.push_back(50); exp_v.push_back(50); exp_v.push_back(60);
`endif
    for (int run = 0; run < 2; run++) begin
      drive_run();
      checks++;
      if (o_dv_v.size() != exp_v.size()) begin
        failures++; $display("FAIL dup run%0d dv_count got %0d exp %0d", run, o_dv_v.size(), exp_v.size());
      end
      for (int i = 0; i < exp_v.size() && i < o_dv_v.size(); i++) begin
        checks++;
        if (o_dv_v[i] != exp_v[i]) begin
          failures++; $display("FAIL dup run%0d din[%0d] got %0d exp %0d", run, i, o_dv_v[i], exp_v[i]);
        end
      end
      checks++;
      if (o_done_t.size() != 1 || o_done_t[0] != 2 * STEP + 4) begin
        failures++; $display("FAIL dup run%0d done got count=%0d exp one at %0d", run, o_done_t.size(), 2 * STEP + 4);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int last = $urandom_range(0, 5);
      for (int i = 0; i <= last; i++) load(i, $urandom_range(0, 7) * 37);
      set_scn(last, $urandom_range(5, 150));
      s_restart = 1;
      if ($urandom_range(0, 2) == 0) s_abort = $urandom_range(0, last * STEP + 40);
      if ($urandom_range(0, 1) == 0) begin
        s_wcyc = 2 * $urandom_range(0, last * STEP / 2) + 1;
        s_waddr = $urandom_range(0, last);
        s_wdata = $urandom_range(0, 1023);
      end
      model_run();
      drive_run();
      checks++;
      if (o_dv_t.size() != e_dv_t.size() || o_done_t.size() != e_done_t.size() ||
          o_ovr_t.size() != e_ovr_t.size() || o_end != e_end) begin
        failures++;
        $display("FAIL rand%0d counts got dv=%0d done=%0d ovr=%0d end=%0d exp dv=%0d done=%0d ovr=%0d end=%0d",
                 r, o_dv_t.size(), o_done_t.size(), o_ovr_t.size(), o_end,
                 e_dv_t.size(), e_done_t.size(), e_ovr_t.size(), e_end);
      end
      for (int i = 0; i < e_dv_t.size() && i < o_dv_t.size(); i++) begin
        checks++;
        if (o_dv_t[i] != e_dv_t[i] || o_dv_v[i] != e_dv_v[i]) begin
          failures++;
          $display("FAIL rand%0d dv[%0d] got t=%0d din=%0d exp t=%0d din=%0d",
                   r, i, o_dv_t[i], o_dv_v[i], e_dv_t[i], e_dv_v[i]);
        end
      end
      for (int i = 0; i < e_ovr_t.size() && i < o_ovr_t.size(); i++) begin
        checks++;
        if (o_ovr_t[i] != e_ovr_t[i]) begin
          failures++; $display("FAIL rand%0d ovr[%0d] got t=%0d exp t=%0d", r, i, o_ovr_t[i], e_ovr_t[i]);
        end
      end
      if (e_done_t.size() == 1 && o_done_t.size() == 1) begin
        checks++;
        if (o_done_t[0] != e_done_t[0]) begin
          failures++; $display("FAIL rand%0d done got t=%0d exp t=%0d", r, o_done_t[0], e_done_t[0]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int seen = 0;
    @(negedge clk);
    bus.cfg_last = ADDR_W'(3); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      if (bus.dac_dvalid === 1'b1) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (seen == 0) begin
      failures++; $display("FAIL async_reset first_dvalid got none within 10 clks exp one");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.dac_din, bus.dac_dvalid, bus.active, bus.done, bus.overrun} !== '0) begin
      failures++;
      $display("FAIL async_reset outputs got din=%0d dv=%b act=%b done=%b ovr=%b exp all 0",
               bus.dac_din, bus.dac_dvalid, bus.active, bus.done, bus.overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_overrun();
    test_abort();
    test_single();
    test_overwrite();
    test_start_abort();
    test_dup();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
